qdma_byp_out_rcv: RTL and testbench
===================================

# qdma_byp_out_rcv

Receiver for the QDMA descriptor-bypass-out channel. It sits on the slave side of the bypass-out interface (256-bit descriptor, 16-bit consumer index, valid/ready) and buffers accepted descriptors in a small FIFO. It presents them to user descriptor-processing logic and emits coalesced consumer-index updates as the user drains them. It sits between the CPM/QDMA bypass-out port and the user bypass engine in the example design.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..64
- COAL_CNT, 4, consumed descriptors per cidx update; 1..DEPTH
- axi_aclk  in  1  sole clock
- axi_rst  in  1  reset; synchronous, active-high
- byp_out_dsc  in  256  descriptor from QDMA
- byp_out_cidx  in  16  consumer index of that descriptor
- byp_out_vld  in  1  descriptor valid
- byp_out_rdy  out  1  receiver ready
- usr_dsc  out  256  head descriptor
- usr_cidx  out  16  head cidx
- usr_vld  out  1  head valid
- usr_rdy  in  1  user consumes head
- cidx_upd  out  16  last consumed cidx
- cidx_upd_vld  out  1  one-cycle update pulse
- fill_lvl  out  $clog2(DEPTH)+1  current FIFO occupancy
- cidx_err  out  1  sticky cidx discontinuity (see Configuration)

## Operation
- Accept: transfer when byp_out_vld && byp_out_rdy; {dsc, cidx} written to FIFO tail.
- Pop: when usr_vld && usr_rdy, head is removed and pend counter increments.
- byp_out_rdy is registered and equals (next occupancy != DEPTH); never depends combinationally on byp_out_vld.
- Push and pop in the same cycle: occupancy unchanged; legal at any non-empty level, including full-minus-one.
- Coalescing: pend counts pops since the last update (width $clog2(DEPTH)+1).
  - A pulse is issued when a pop makes pend == COAL_CNT (count trigger).
  - A pulse is also issued when a pop leaves the FIFO empty with pend > 0 (flush trigger).
  - If both triggers fire in the same cycle, one pulse is issued.
  - On a pulse, cidx_upd = cidx of the popping descriptor and pend clears to 0; a pop in the same cycle is counted into the cleared value only if it is a later pop (there is none; one pop per cycle max).
- cidx arithmetic is modulo 2^16; 0xFFFF followed by 0x0000 is continuous.
- Reset mid-operation: FIFO contents are discarded, pend = 0, checker is re-armed; no update is issued for discarded entries.

## Timing
- Reset values: byp_out_rdy=0, usr_vld=0, usr_dsc=0, usr_cidx=0, cidx_upd=0, cidx_upd_vld=0, fill_lvl=0, cidx_err=0.
- byp_out_rdy rises 1 cycle after axi_rst deasserts.
- Accept-to-usr_vld latency: 1 cycle into an empty FIFO (registered head, first-word fall-through).
- usr_dsc/usr_cidx stay stable while usr_vld && !usr_rdy.
- cidx_upd_vld asserts the cycle after the triggering pop, for exactly one cycle.
- fill_lvl is registered and reflects the transfers of the previous cycle.
- Full: byp_out_rdy=0 in the cycle after occupancy reaches DEPTH, and it stays 0 until a pop occurs. After that pop, byp_out_rdy=1 in the next cycle.
- Sustained throughput: one accept plus one pop per cycle.

## Configuration
- BYP_OUT_CIDX_CHK_EN defined: enables the cidx continuity checker.
  - The first accept after reset loads expected = cidx+1.
  - Each later accept with cidx != expected sets cidx_err, which stays high until axi_rst.
  - expected is always reloaded to the received cidx+1.
  - cidx_err asserts 1 cycle after the offending accept.
- BYP_OUT_CIDX_CHK_EN undefined: no checker logic is generated and cidx_err is tied to 0.

## Structure
- Package qdma_byp_pkg: BYP_DSC_W=256, BYP_CIDX_W=16, typedef byp_dsc_t, typedef byp_entry_t (packed {cidx, dsc}).
- Sub-module qdma_byp_sync_fifo: parameterized synchronous FIFO of byp_entry_t. It provides registered head, full/empty and count outputs.
- Ready generation, coalescing and the checker live in the top module.

## Test plan
- Single descriptor: cidx=0x0005 accepted at T → usr_vld at T+1; pop at T+1 → cidx_upd=0x0005, cidx_upd_vld pulse at T+2 (flush trigger).
- Backpressure fill: usr_rdy=0, 20 back-to-back accepts, DEPTH=16.
  - Required: exactly 16 accepted, byp_out_rdy=0 from the cycle after the 16th, fill_lvl=16.
  - One pop: byp_out_rdy=1 next cycle.
- Coalescing: COAL_CNT=4, cidx 0..9 streamed with usr_rdy=1 continuously, no input gaps.
  - Required: pulses with cidx_upd=0x0003 and 0x0007 (count trigger), then 0x0009 (flush trigger).
- Wrap: cidx 0xFFFE, 0xFFFF, 0x0000, 0x0001 → cidx_err stays 0, data and order preserved.
- Discontinuity (BYP_OUT_CIDX_CHK_EN): cidx 0x0010, 0x0012.
  - Required: cidx_err=1 one cycle after the second accept, and it holds.
  - Follow with 0x0013: cidx_err stays 1, no new error source.
- Reset mid-stream: 6 entries queued, axi_rst pulsed.
  - Required: usr_vld=0, fill_lvl=0, no cidx_upd_vld, byp_out_rdy=0 during reset and 1 the cycle after.

Source files
------------

// File: rtl/qdma_byp_out_rcv_pkg.sv
// Shared types for the QDMA bypass-out receiver: descriptor, cidx and FIFO entry.
package qdma_byp_pkg;

    localparam int unsigned BYP_DSC_W  = 256;
    localparam int unsigned BYP_CIDX_W = 16;

    typedef logic [BYP_DSC_W-1:0]  byp_dsc_t;
    typedef logic [BYP_CIDX_W-1:0] byp_cidx_t;

    typedef struct packed {
        byp_cidx_t cidx;
        byp_dsc_t  dsc;
    } byp_entry_t;

endpackage

// File: rtl/qdma_byp_out_rcv_if.sv
// Descriptor stream (dsc/cidx with valid/ready) used for bypass-out and user sides.
interface qdma_byp_if;
    import qdma_byp_pkg::*;

    byp_dsc_t  dsc;
    byp_cidx_t cidx;
    logic      vld;
    logic      rdy;

    modport master (output dsc, output cidx, output vld, input rdy);
    modport slave  (input dsc, input cidx, input vld, output rdy);

endinterface

// File: rtl/qdma_byp_out_rcv_sync_fifo.sv
// Synchronous first-word-fall-through FIFO of bypass entries; head is driven
// straight from the storage registers and reads as zero while empty.
module qdma_byp_sync_fifo
    import qdma_byp_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  byp_entry_t             wr_data,
    input  logic                   rd_en,
    output byp_entry_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    byp_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_ok;
    logic            rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qdma_byp_out_rcv.sv
// QDMA descriptor-bypass-out receiver: buffers descriptors, presents them to the
// user and emits coalesced consumer-index updates.
// Optional: define BYP_OUT_CIDX_CHK_EN to build the cidx continuity checker.
module qdma_byp_out_rcv
    import qdma_byp_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned COAL_CNT = 4
) (
    input  logic                   axi_aclk,
    input  logic                   axi_rst,
    qdma_byp_if.slave              byp_out,
    qdma_byp_if.master             usr,
    output byp_cidx_t              cidx_upd,
    output logic                   cidx_upd_vld,
    output logic [$clog2(DEPTH):0] fill_lvl,
    output logic                   cidx_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          rdy_q;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    byp_entry_t    wr_ent;
    byp_entry_t    head;
    logic [CW-1:0] nxt_lvl;
    logic [CW-1:0] pend;
    logic [CW-1:0] pend_inc;
    logic          upd_fire;

    assign wr_ent.cidx = byp_out.cidx;
    assign wr_ent.dsc  = byp_out.dsc;
    assign byp_out.rdy = rdy_q;
    assign push        = byp_out.vld && rdy_q && !fifo_full;
    assign pop         = usr.vld && usr.rdy;
    assign usr.vld     = !fifo_empty;
    assign usr.dsc     = head.dsc;
    assign usr.cidx    = head.cidx;

    qdma_byp_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst     (axi_rst),
        .wr_en   (push),
        .wr_data (wr_ent),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_lvl)
    );

    // Occupancy after this cycle's transfers, used for ready and flush detection.
    always_comb begin
        nxt_lvl = fill_lvl;
        if (push && !pop) begin
            nxt_lvl = fill_lvl + 1'b1;
        end else if (!push && pop) begin
            nxt_lvl = fill_lvl - 1'b1;
        end
    end

    // Registered ready: drops the cycle the FIFO becomes full.
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (nxt_lvl != CW'(DEPTH));
        end
    end

    // Update trigger: pop reaching COAL_CNT, or pop draining the FIFO.
    always_comb begin
        pend_inc = pend + 1'b1;
        upd_fire = pop && ((pend_inc == CW'(COAL_CNT)) || (nxt_lvl == '0));
    end

    // Coalescing counter and one-cycle cidx update pulse.
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            pend         <= '0;
            cidx_upd     <= '0;
            cidx_upd_vld <= 1'b0;
        end else begin
            cidx_upd_vld <= upd_fire;
            if (upd_fire) begin
                cidx_upd <= head.cidx;
                pend     <= '0;
            end else if (pop) begin
                pend <= pend_inc;
            end
        end
    end

`ifdef BYP_OUT_CIDX_CHK_EN
    logic      chk_armed;
    byp_cidx_t cidx_exp;

    // Continuity checker: sticky error when an accepted cidx breaks the sequence.
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            chk_armed <= 1'b0;
            cidx_exp  <= '0;
            cidx_err  <= 1'b0;
        end else if (push) begin
            chk_armed <= 1'b1;
            cidx_exp  <= byp_out.cidx + 1'b1;
            if (chk_armed && (byp_out.cidx != cidx_exp)) begin
                cidx_err <= 1'b1;
            end
        end
    end
`else
    assign cidx_err = 1'b0;
`endif

endmodule

// File: tb/tb_qdma_byp_out_rcv.sv
// Directed self-checking bench for qdma_byp_out_rcv (DEPTH=16, COAL_CNT=4).
module tb_qdma_byp_out_rcv;

    logic        clk;
    logic        rst;
    logic [15:0] cidx_upd;
    logic        cidx_upd_vld;
    logic [4:0]  fill_lvl;
    logic        cidx_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] upd_q[$];

`ifdef BYP_OUT_CIDX_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    qdma_byp_if byp_out ();
    qdma_byp_if usr ();

    qdma_byp_out_rcv #(
        .DEPTH    (16),
        .COAL_CNT (4)
    ) dut (
        .axi_aclk     (clk),
        .axi_rst      (rst),
        .byp_out      (byp_out),
        .usr          (usr),
        .cidx_upd     (cidx_upd),
        .cidx_upd_vld (cidx_upd_vld),
        .fill_lvl     (fill_lvl),
        .cidx_err     (cidx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle the update pulse is high.
    always @(negedge clk) begin
        if (cidx_upd_vld) upd_q.push_back(cidx_upd);
    end

    function automatic logic [255:0] mkdsc(input logic [15:0] c);
        return {8{c, ~c}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byp_out.vld = 1'b0;
        usr.rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        byp_out.vld  = 1'b0;
        byp_out.dsc  = '0;
        byp_out.cidx = '0;
        usr.rdy      = 1'b0;
        tick();
        tick();
        n_checks++; if (byp_out.rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy got=%b exp=0", byp_out.rdy); end
        n_checks++; if (usr.vld !== 1'b0) begin n_fail++; $display("FAIL rst_usr_vld got=%b exp=0", usr.vld); end
        n_checks++; if (usr.dsc !== 256'h0) begin n_fail++; $display("FAIL rst_usr_dsc got=%h exp=0", usr.dsc); end
        n_checks++; if (usr.cidx !== 16'h0) begin n_fail++; $display("FAIL rst_usr_cidx got=%h exp=0", usr.cidx); end
        n_checks++; if (cidx_upd !== 16'h0) begin n_fail++; $display("FAIL rst_cidx_upd got=%h exp=0", cidx_upd); end
        n_checks++; if (cidx_upd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_upd_vld got=%b exp=0", cidx_upd_vld); end
        n_checks++; if (fill_lvl !== 5'd0) begin n_fail++; $display("FAIL rst_fill got=%0d exp=0", fill_lvl); end
        n_checks++; if (cidx_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", cidx_err); end
        rst = 1'b0;
        n_checks++; if (byp_out.rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_rel0 got=%b exp=0", byp_out.rdy); end
        tick();
        n_checks++; if (byp_out.rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_rel1 got=%b exp=1", byp_out.rdy); end
    endtask

    task automatic test_single();
        upd_q.delete();
        byp_out.vld  = 1'b1;
        byp_out.cidx = 16'h0005;
        byp_out.dsc  = mkdsc(16'h0005);
        tick();
        byp_out.vld = 1'b0;
        n_checks++; if (usr.vld !== 1'b1) begin n_fail++; $display("FAIL single_vld got=%b exp=1", usr.vld); end
        n_checks++; if (usr.cidx !== 16'h0005) begin n_fail++; $display("FAIL single_cidx got=%h exp=0005", usr.cidx); end
        n_checks++; if (usr.dsc !== mkdsc(16'h0005)) begin n_fail++; $display("FAIL single_dsc got=%h", usr.dsc); end
        n_checks++; if (fill_lvl !== 5'd1) begin n_fail++; $display("FAIL single_fill got=%0d exp=1", fill_lvl); end
        usr.rdy = 1'b1;
        tick();
        usr.rdy = 1'b0;
        n_checks++; if (cidx_upd_vld !== 1'b1) begin n_fail++; $display("FAIL single_upd_vld got=%b exp=1", cidx_upd_vld); end
        n_checks++; if (cidx_upd !== 16'h0005) begin n_fail++; $display("FAIL single_upd got=%h exp=0005", cidx_upd); end
        n_checks++; if (usr.vld !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", usr.vld); end
        tick();
        n_checks++; if (cidx_upd_vld !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len got=%b exp=0", cidx_upd_vld); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int k = 0;
        usr.rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            byp_out.vld  = 1'b1;
            byp_out.cidx = 16'h0100 + 16'(i);
            byp_out.dsc  = mkdsc(16'h0100 + 16'(i));
            if (i == 16) begin
                n_checks++; if (byp_out.rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_after16 got=%b exp=0", byp_out.rdy); end
            end
            if (byp_out.rdy === 1'b1) acc++;
            tick();
        end
        byp_out.vld = 1'b0;
        n_checks++; if (acc != 16) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=16", acc); end
        n_checks++; if (fill_lvl !== 5'd16) begin n_fail++; $display("FAIL bp_fill got=%0d exp=16", fill_lvl); end
        n_checks++; if (byp_out.rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full got=%b exp=0", byp_out.rdy); end
        n_checks++; if (usr.cidx !== 16'h0100) begin n_fail++; $display("FAIL bp_head got=%h exp=0100", usr.cidx); end
        usr.rdy = 1'b1;
        tick();
        usr.rdy = 1'b0;
        n_checks++; if (byp_out.rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_pop got=%b exp=1", byp_out.rdy); end
        n_checks++; if (fill_lvl !== 5'd15) begin n_fail++; $display("FAIL bp_fill_pop got=%0d exp=15", fill_lvl); end
        usr.rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (usr.vld !== 1'b1) break;
            n_checks++;
            if (usr.cidx !== 16'h0101 + 16'(k)) begin
                n_fail++; $display("FAIL bp_order got=%h exp=%h", usr.cidx, 16'h0101 + 16'(k));
            end
            k++;
            tick();
        end
        usr.rdy = 1'b0;
        n_checks++; if (k != 15) begin n_fail++; $display("FAIL bp_drain_cnt got=%0d exp=15", k); end
        tick();
        tick();
    endtask

    task automatic test_coalesce();
        upd_q.delete();
        usr.rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            byp_out.vld  = 1'b1;
            byp_out.cidx = 16'(i);
            byp_out.dsc  = mkdsc(16'(i));
            tick();
        end
        byp_out.vld = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        usr.rdy = 1'b0;
        n_checks++;
        if (upd_q.size() != 3) begin
            n_fail++; $display("FAIL coal_npulse got=%0d exp=3", upd_q.size());
        end else begin
            n_checks++; if (upd_q[0] !== 16'h0003) begin n_fail++; $display("FAIL coal_p0 got=%h exp=0003", upd_q[0]); end
            n_checks++; if (upd_q[1] !== 16'h0007) begin n_fail++; $display("FAIL coal_p1 got=%h exp=0007", upd_q[1]); end
            n_checks++; if (upd_q[2] !== 16'h0009) begin n_fail++; $display("FAIL coal_p2 got=%h exp=0009", upd_q[2]); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] seq [4];
        int k = 0;
        seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000; seq[3] = 16'h0001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            byp_out.vld  = 1'b1;
            byp_out.cidx = seq[i];
            byp_out.dsc  = mkdsc(seq[i]);
            tick();
        end
        byp_out.vld = 1'b0;
        n_checks++; if (fill_lvl !== 5'd4) begin n_fail++; $display("FAIL wrap_fill got=%0d exp=4", fill_lvl); end
        n_checks++; if (cidx_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got=%b exp=0", cidx_err); end
        usr.rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (usr.vld !== 1'b1 || k >= 4) break;
            n_checks++;
            if (usr.cidx !== seq[k] || usr.dsc !== mkdsc(seq[k])) begin
                n_fail++; $display("FAIL wrap_data got=%h exp=%h", usr.cidx, seq[k]);
            end
            k++;
            tick();
        end
        usr.rdy = 1'b0;
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL wrap_cnt got=%0d exp=4", k); end
        tick();
    endtask

    task automatic test_discontinuity();
        do_reset();
        usr.rdy = 1'b1;
        byp_out.vld  = 1'b1;
        byp_out.cidx = 16'h0010;
        byp_out.dsc  = mkdsc(16'h0010);
        tick();
        n_checks++; if (cidx_err !== 1'b0) begin n_fail++; $display("FAIL disc_first got=%b exp=0", cidx_err); end
        byp_out.cidx = 16'h0012;
        byp_out.dsc  = mkdsc(16'h0012);
        tick();
        byp_out.vld = 1'b0;
        n_checks++; if (cidx_err !== EXP_ERR) begin n_fail++; $display("FAIL disc_err got=%b exp=%b", cidx_err, EXP_ERR); end
        tick();
        n_checks++; if (cidx_err !== EXP_ERR) begin n_fail++; $display("FAIL disc_hold got=%b exp=%b", cidx_err, EXP_ERR); end
        byp_out.vld  = 1'b1;
        byp_out.cidx = 16'h0013;
        byp_out.dsc  = mkdsc(16'h0013);
        tick();
        byp_out.vld = 1'b0;
        tick();
        n_checks++; if (cidx_err !== EXP_ERR) begin n_fail++; $display("FAIL disc_sticky got=%b exp=%b", cidx_err, EXP_ERR); end
        usr.rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        n_checks++; if (cidx_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_clr got=%b exp=0", cidx_err); end
        usr.rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byp_out.vld  = 1'b1;
            byp_out.cidx = 16'h0200 + 16'(i);
            byp_out.dsc  = mkdsc(16'h0200 + 16'(i));
            tick();
        end
        byp_out.vld = 1'b0;
        n_checks++; if (fill_lvl !== 5'd6) begin n_fail++; $display("FAIL mid_fill6 got=%0d exp=6", fill_lvl); end
        upd_q.delete();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (usr.vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld got=%b exp=0", usr.vld); end
            n_checks++; if (fill_lvl !== 5'd0) begin n_fail++; $display("FAIL mid_fill got=%0d exp=0", fill_lvl); end
            n_checks++; if (byp_out.rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rdy got=%b exp=0", byp_out.rdy); end
        end
        rst = 1'b0;
        usr.rdy = 1'b1;
        tick();
        n_checks++; if (byp_out.rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy_rel got=%b exp=1", byp_out.rdy); end
        n_checks++; if (usr.vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld_rel got=%b exp=0", usr.vld); end
        for (int i = 0; i < 4; i++) tick();
        usr.rdy = 1'b0;
        n_checks++; if (upd_q.size() != 0) begin n_fail++; $display("FAIL mid_no_upd got=%0d exp=0", upd_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_coalesce();
        test_wrap();
        test_discontinuity();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
